// File: rtl/ddr2_cmd_checker_pkg.sv
// Shared definitions for the DDR2 command-bus checker: command codes, error bit
// indices and the burst-length decode.
package ddr2_cmd_checker_pkg;

   typedef enum logic [2:0] {
      NOP0 = 3'd0,
      SRD  = 3'd1,
      SWR  = 3'd2,
      BRD  = 3'd3,
      BWR  = 3'd4,
      ARD  = 3'd5,
      AWR  = 3'd6,
      NOP7 = 3'd7
   } cmd_t;

   typedef enum int {
      E_CMDX  = 0,
      E_ADDRX = 1,
      E_DINX  = 2,
      E_SZX   = 3,
      E_FETCH = 4,
      E_OVLP  = 5,
      E_WRAP  = 6,
      E_TMO   = 7
   } err_idx_e;

   localparam int ERR_W = 8;

   // (sz+1)*8 words: 8, 16, 24 or 32.
   function automatic logic [5:0] burst_len(input logic [1:0] sz);
      logic [2:0] beats;
      beats = {1'b0, sz} + 3'd1;
      return {beats, 3'b000};
   endfunction

endpackage

// File: rtl/ddr2_cmd_checker_if.sv
// Driver -> DDR2 controller command bus. The driver owns every signal; the
// checker only observes through the slave modport.
interface ddr2_cmd_checker_if #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16
);
   logic [2:0]        cmd;
   logic [1:0]        sz;
   logic              fetching;
   logic [DATA_W-1:0] din;
   logic [ADDR_W-1:0] addr;

   modport master (output cmd, sz, fetching, din, addr);
   modport slave  (input  cmd, sz, fetching, din, addr);
endinterface

// File: rtl/ddr2_cmd_checker_burst_tracker.sv
// Block-write burst tracker: counts remaining fetches of an open block write and
// the cycles it has been open; raw timeout is qualified by the caller with done.
module ddr2_burst_tracker #(
   parameter int TIMEOUT = 256
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       fetch,
   input  logic [5:0] len,
   output logic       active,
   output logic       done,
   output logic       timeout
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] BLK_WR = 1'b1;

   logic [0:0]       state;
   logic [5:0]       remaining;
   logic [TMO_W-1:0] tmo;

   assign active  = (state == BLK_WR);
   assign done    = active && fetch && (remaining == 6'd1);
   assign timeout = active && (tmo == TMO_W'(TIMEOUT - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of the order of statements in the block.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         remaining <= '0;
         tmo       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= BLK_WR;
                  remaining <= len;
                  tmo       <= '0;
               end
            end
            default: begin
               if (fetch) remaining <= remaining - 6'd1;
               tmo <= tmo + 1'b1;
               // A completing fetch and the timeout limit both end the burst.
               if (done || timeout) state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/ddr2_cmd_checker.sv
// Passive protocol checker on the DDR2 command bus: X/Z, range and burst checks
// feeding sticky error flags plus saturating error and wrapping command counters.
module ddr2_cmd_checker
   import ddr2_cmd_checker_pkg::*;
#(
   parameter int ADDR_W  = 25,
   parameter int DATA_W  = 16,
   parameter int COL_W   = 10,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 256
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ddr2_cmd_checker_if.slave    bus,
   input  logic                 clr,
   output logic [ERR_W-1:0]     err_vec,
   output logic                 err_pulse,
   output logic [CNT_W-1:0]     err_count,
   output logic [CNT_W-1:0]     cmd_count,
   output logic                 blk_active
);
   localparam logic [COL_W:0] COL_SPAN = (COL_W + 1)'(1) << COL_W;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              cmd_x, sz_x, addr_x, din_x;
   logic              is_cmd, is_blk, is_long;
   logic [5:0]        len;
   logic [COL_W:0]    col_end;
   logic              trk_active, trk_done, trk_timeout;
   logic [ERR_W-1:0]  new_err;

   assign addr   = bus.addr;
   assign din    = bus.din;
   assign cmd_x  = $isunknown(bus.cmd);
   assign sz_x   = $isunknown(bus.sz);
   assign addr_x = $isunknown(addr);
   assign din_x  = $isunknown(din);

   // Every decode is gated by !cmd_x so an unknown command never looks legal.
   assign is_cmd  = !cmd_x && (bus.cmd != NOP0) && (bus.cmd != NOP7);
   assign is_blk  = !cmd_x && ((bus.cmd == BRD) || (bus.cmd == BWR));
   assign is_long = !cmd_x && (bus.cmd inside {BRD, BWR, ARD, AWR});

   assign len     = burst_len(sz_x ? 2'd0 : bus.sz);
   assign col_end = {1'b0, addr[COL_W-1:0]} + (COL_W + 1)'(len);

   ddr2_burst_tracker #(.TIMEOUT(TIMEOUT)) u_tracker (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (!cmd_x && (bus.cmd == BWR) && !trk_active),
      .fetch   (bus.fetching),
      .len     (len),
      .active  (trk_active),
      .done    (trk_done),
      .timeout (trk_timeout)
   );

   assign blk_active = trk_active;

   // NOTE: every combinational output gets a default first so no path through
   // the block can leave a bit unassigned and infer a latch.
   always_comb begin
      new_err          = '0;
      new_err[E_CMDX]  = cmd_x && !trk_active;
      new_err[E_ADDRX] = is_cmd && addr_x;
      new_err[E_DINX]  = trk_active && bus.fetching && din_x;
      new_err[E_SZX]   = is_long && sz_x;
      new_err[E_FETCH] = bus.fetching && !trk_active;
      new_err[E_OVLP]  = is_cmd && trk_active;
      new_err[E_WRAP]  = is_blk && !sz_x && !addr_x && (col_end > COL_SPAN);
      new_err[E_TMO]   = trk_timeout && !trk_done;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_vec   <= '0;
         err_pulse <= 1'b0;
         err_count <= '0;
         cmd_count <= '0;
      end else begin
         err_pulse <= |new_err;
         // A same-cycle violation survives clr: the clear restarts from this cycle.
         if (clr) begin
            err_vec   <= new_err;
            err_count <= CNT_W'(|new_err);
            cmd_count <= CNT_W'(is_cmd);
         end else begin
            err_vec <= err_vec | new_err;
            if ((|new_err) && (err_count != '1)) err_count <= err_count + 1'b1;
            cmd_count <= cmd_count + CNT_W'(is_cmd);
         end
      end
   end

endmodule
